// File: rtl/asp_irq_ctrl_if.sv
// Host CSR (AVMM) slave bus, BSP interrupt lines and shell-side vector handshake for asp_irq_ctrl.
interface asp_irq_ctrl_if #(
  parameter int NUM_IRQ    = 4,
  parameter int CSR_ADDR_W = 3,
  parameter int CSR_DATA_W = 64
);
  localparam int VEC_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0]      irq_in;
  logic [CSR_ADDR_W-1:0]   csr_address;
  logic                    csr_read;
  logic                    csr_write;
  logic [CSR_DATA_W-1:0]   csr_writedata;
  logic [CSR_DATA_W/8-1:0] csr_byteenable;
  logic [CSR_DATA_W-1:0]   csr_readdata;
  logic                    csr_readdatavalid;
  logic                    csr_waitrequest;
  logic                    irq_req;
  logic [VEC_W-1:0]        irq_vector;
  logic                    irq_ack;

  modport master (
    output irq_in, csr_address, csr_read, csr_write, csr_writedata, csr_byteenable, irq_ack,
    input  csr_readdata, csr_readdatavalid, csr_waitrequest, irq_req, irq_vector
  );

  modport slave (
    input  irq_in, csr_address, csr_read, csr_write, csr_writedata, csr_byteenable, irq_ack,
    output csr_readdata, csr_readdatavalid, csr_waitrequest, irq_req, irq_vector
  );
endinterface

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt responder: pending/enable/in-service CSRs, round-robin vector req/ack to the shell.
// Define ASP_IRQ_EDGE_DETECT_EN for rising-edge capture of irq_in; default is level-sensitive.
module asp_irq_ctrl #(
  parameter int NUM_IRQ    = 4,
  parameter int NUM_USED   = 3,
  parameter int CSR_ADDR_W = 3,
  parameter int CSR_DATA_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  asp_irq_ctrl_if.slave bus
);
  localparam int VEC_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [NUM_IRQ-1:0]    LIVE     = NUM_IRQ'((64'd1 << NUM_USED) - 64'd1);
  localparam logic [CSR_ADDR_W-1:0] A_STATUS = CSR_ADDR_W'(0);
  localparam logic [CSR_ADDR_W-1:0] A_CLEAR  = CSR_ADDR_W'(1);
  localparam logic [CSR_ADDR_W-1:0] A_ENABLE = CSR_ADDR_W'(2);
  localparam logic [CSR_ADDR_W-1:0] A_SENT   = CSR_ADDR_W'(3);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t                 state, state_nxt;
  logic [NUM_IRQ-1:0]     irq_p0;
  logic [NUM_IRQ-1:0]     src;
  logic [NUM_IRQ-1:0]     pending, in_service, enable;
  logic [NUM_IRQ-1:0]     cand, clr, ack_bits;
  logic [31:0]            sent_cnt;
  logic [VEC_W-1:0]       vec, last_ack, winner, probe;
  logic                   found, load_vec, ack_fire, wr_en;
  logic [CSR_DATA_W-1:0]  rd_mux, rdata;
  logic                   rvalid;
  int                     idx;

  // Stage p0: irq_in is registered before it can touch pending
`ifdef ASP_IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] irq_p1;
  always_ff @(posedge clk) begin
    if (reset) irq_p1 <= '0;
    else       irq_p1 <= irq_p0;
  end
  assign src = irq_p0 & ~irq_p1;
`else
  assign src = irq_p0;
`endif

  assign wr_en    = bus.csr_write && bus.csr_byteenable[0];
  assign clr      = (wr_en && bus.csr_address == A_CLEAR) ? bus.csr_writedata[NUM_IRQ-1:0] : '0;
  assign cand     = pending & enable & ~in_service;
  assign ack_bits = ack_fire ? (NUM_IRQ'(1) << vec) : '0;

  // Round-robin: search starts one past the last acked vector
  always_comb begin
    winner = last_ack;
    found  = 1'b0;
    idx    = 0;
    probe  = '0;
    for (int k = 1; k <= NUM_IRQ; k++) begin
      idx   = (int'(last_ack) + k) % NUM_IRQ;
      probe = VEC_W'(idx);
      if (!found && cand[probe]) begin
        winner = probe;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_vec  = 1'b0;
    ack_fire  = 1'b0;
    unique case (state)
      S_IDLE: if (found) begin
        load_vec  = 1'b1;
        state_nxt = S_REQ;
      end
      S_REQ: if (bus.irq_ack) begin
        ack_fire  = 1'b1;
        state_nxt = S_GAP;
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (bus.csr_address)
      A_STATUS: begin
        rd_mux[NUM_IRQ-1:0]  = pending;
        rd_mux[8 +: NUM_IRQ] = in_service;
      end
      A_ENABLE: rd_mux[NUM_IRQ-1:0] = enable;
      A_SENT:   rd_mux[31:0]        = sent_cnt;
      default:  rd_mux = '0;
    endcase
  end

  // Stage p1: CSR state, pending capture (set beats clear), vector and read response
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_p0     <= '0;
      pending    <= '0;
      in_service <= '0;
      enable     <= '0;
      sent_cnt   <= '0;
      vec        <= '0;
      last_ack   <= VEC_W'(NUM_IRQ - 1);
      rdata      <= '0;
      rvalid     <= 1'b0;
    end else begin
      irq_p0     <= bus.irq_in;
      pending    <= (pending & ~clr) | (src & LIVE);
      in_service <= (in_service | ack_bits) & ~clr;
      if (wr_en && bus.csr_address == A_ENABLE) enable <= bus.csr_writedata[NUM_IRQ-1:0];
      if (load_vec) vec <= winner;
      if (ack_fire) begin
        sent_cnt <= sent_cnt + 32'd1;
        last_ack <= vec;
      end
      rvalid <= bus.csr_read;
      if (bus.csr_read) rdata <= rd_mux;
    end
  end

  assign bus.csr_readdata      = rdata;
  assign bus.csr_readdatavalid = rvalid;
  assign bus.csr_waitrequest   = 1'b0;
  assign bus.irq_req           = (state == S_REQ);
  assign bus.irq_vector        = vec;

  logic unused_bits;
  assign unused_bits = ^{bus.csr_writedata[CSR_DATA_W-1:NUM_IRQ], bus.csr_byteenable[CSR_DATA_W/8-1:1]};
endmodule
